// File: rtl/tri_raster_engine_pkg.sv
// Shared types for the triangle rasteriser.
//   point_t        : unsigned screen coordinate pair
//   color_t        : RGB565 colour
//   triangle_t     : three vertices plus one colour per vertex (v0 in the MSBs)
//   raster_state_t : frame sequencer states
//   fb_addr()      : linear framebuffer address x + width*y
package tri_raster_engine_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 16;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef struct packed {
    point_t v0;
    point_t v1;
    point_t v2;
    color_t c0;
    color_t c1;
    color_t c2;
  } triangle_t;

  localparam int TRI_BITS = $bits(triangle_t);

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    FETCH,
    LOAD,
    DIV_START,
    DIV_WAIT,
    SETUP,
    RASTER,
    NEXT,
    DONE
  } raster_state_t;

  // 32-bit intermediate, so any in-range coordinate pair cannot wrap.
  function automatic logic [31:0] fb_addr(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y,
                                          input int width);
    fb_addr = 32'(x) + 32'(width) * 32'(y);
  endfunction

endpackage

// File: rtl/tri_raster_engine_bbox_scanner.sv
// Row-major scanner over a latched bounding box.
//   clk, rst        : clock, synchronous active-high reset
//   load            : latch bounds and restart at (min_x, min_y)
//   advance         : step to the next candidate pixel
//   min_x..max_y    : inclusive bounds, already clamped to the display
//   x, y            : current candidate pixel
//   last            : current pixel is (max_x, max_y)
module tri_raster_engine_bbox_scanner
  import tri_raster_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] max_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] min_x_q;
  logic [COORD_W-1:0] max_x_q;
  logic [COORD_W-1:0] max_y_q;
  logic               unused_rst;

  // Position and bounds are pure data; the sequencer only looks at them
  // after a load, so they carry no reset.
  assign unused_rst = rst;

  always_ff @(posedge clk) begin
    if (load) begin
      min_x_q <= min_x;
      max_x_q <= max_x;
      max_y_q <= max_y;
      x       <= min_x;
      y       <= min_y;
    end else if (advance) begin
      if (x == max_x_q) begin
        x <= min_x_q;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == max_x_q) && (y == max_y_q);

endmodule

// File: rtl/tri_raster_engine.sv
// Frame-level triangle rasteriser. On start it optionally clears the
// framebuffer, then for each triangle fetches it from VRAM, computes the
// edge-function area, inverts it with an iterative divider, and scans the
// bounding box writing barycentric-shaded pixels.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a frame (ignored while busy)
//   clear_en       : with start, run a clear pass first
//   num_tris       : with start, triangles this frame (clamped to MAX_TRIS)
//   busy           : frame in progress
//   frame_done     : one-cycle pulse at end of frame
//   tris_drawn     : triangles not skipped in the last frame
//   vram_rd_addr   : triangle index; data returns one cycle later
//   vram_rd_data   : packed triangle_t
//   fb_wr_valid/ready/addr/data : framebuffer write port
module tri_raster_engine
  import tri_raster_engine_pkg::*;
#(
  parameter int                      DISPLAY_WIDTH  = 100,
  parameter int                      DISPLAY_HEIGHT = 100,
  parameter int                      MAX_TRIS       = 16,
  parameter int                      VRAM_ADDR_BITS = $clog2(MAX_TRIS),
  parameter int                      FB_DATA_BITS   = 16,
  parameter int                      FB_ADDR_BITS   = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT),
  parameter logic [FB_DATA_BITS-1:0] CLEAR_COLOR    = '0,
  parameter bit                      CULL_BACKFACE  = 1'b0,
  parameter int                      DIV_BITS       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clear_en,
  input  logic [VRAM_ADDR_BITS:0]   num_tris,
  output logic                      busy,
  output logic                      frame_done,
  output logic [VRAM_ADDR_BITS:0]   tris_drawn,
  output logic [VRAM_ADDR_BITS-1:0] vram_rd_addr,
  input  logic [TRI_BITS-1:0]       vram_rd_data,
  output logic                      fb_wr_valid,
  input  logic                      fb_wr_ready,
  output logic [FB_ADDR_BITS-1:0]   fb_wr_addr,
  output logic [FB_DATA_BITS-1:0]   fb_wr_data
);

  localparam logic [VRAM_ADDR_BITS:0] MAX_N    = (VRAM_ADDR_BITS+1)'(MAX_TRIS);
  localparam logic [FB_ADDR_BITS-1:0] CLR_LAST = FB_ADDR_BITS'(DISPLAY_WIDTH*DISPLAY_HEIGHT-1);
  localparam logic [COORD_W-1:0]      X_LIM    = COORD_W'(DISPLAY_WIDTH-1);
  localparam logic [COORD_W-1:0]      Y_LIM    = COORD_W'(DISPLAY_HEIGHT-1);
  localparam int                      CNT_W    = $clog2(DIV_BITS) + 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DIV_BITS-1);

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------
  function automatic logic signed [31:0] edge_fn(input point_t a, input point_t b,
                                                 input point_t p);
    logic signed [31:0] dx_ab, dy_ab, dx_ap, dy_ap;
    dx_ab   = $signed(32'(b.x)) - $signed(32'(a.x));
    dy_ab   = $signed(32'(b.y)) - $signed(32'(a.y));
    dx_ap   = $signed(32'(p.x)) - $signed(32'(a.x));
    dy_ap   = $signed(32'(p.y)) - $signed(32'(a.y));
    edge_fn = dx_ab * dy_ap - dy_ab * dx_ap;
  endfunction

  // Round-to-nearest removal of the 2^(DIV_BITS-1) scale of the inverse.
  // Without it a flat-coloured triangle comes out one LSB dark, because
  // the truncated inverse times the area falls just short of the scale.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v);
    round_shift = (v + (64'sd1 <<< (DIV_BITS-2))) >>> (DIV_BITS-1);
  endfunction

  function automatic logic [5:0] sat_ch(input logic signed [63:0] v,
                                        input logic [5:0] maxv);
    if (v < 0)                            sat_ch = '0;
    else if (v > $signed({58'd0, maxv}))  sat_ch = maxv;
    else                                  sat_ch = v[5:0];
  endfunction

  function automatic logic [5:0] shade_ch(input logic signed [31:0] w0,
                                          input logic signed [31:0] w1,
                                          input logic signed [31:0] w2,
                                          input logic [5:0] c0,
                                          input logic [5:0] c1,
                                          input logic [5:0] c2,
                                          input logic [DIV_BITS-1:0] inv,
                                          input logic [5:0] maxv);
    logic signed [63:0] acc, prod;
    acc  = 64'(w0) * $signed(64'(c0)) + 64'(w1) * $signed(64'(c1))
         + 64'(w2) * $signed(64'(c2));
    prod = acc * $signed(64'(inv));
    shade_ch = sat_ch(round_shift(prod), maxv);
  endfunction

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m    = (a < b) ? a : b;
    min3 = (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m    = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input logic [COORD_W-1:0] lim);
    clamp = (v > lim) ? lim : v;
  endfunction

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  raster_state_t             state, state_n;
  logic [VRAM_ADDR_BITS:0]   ntris_q;
  logic [VRAM_ADDR_BITS:0]   start_ntris;
  logic [VRAM_ADDR_BITS-1:0] idx;
  logic [FB_ADDR_BITS-1:0]   clr_addr;
  logic                      pass_done;
  logic                      out_free;

  triangle_t                 tri_in;
  logic signed [31:0]        area_in;
  logic                      skip_in;
  triangle_t                 tri_q;
  logic signed [31:0]        area_q;
  logic signed [31:0]        area_abs;
  logic                      area_neg;
  logic [DIV_BITS-1:0]       inv_q;

  logic                      div_start;
  logic [DIV_BITS-1:0]       div_den;
  logic                      div_busy;
  logic                      div_valid;
  logic [CNT_W-1:0]          div_cnt;
  logic [DIV_BITS-1:0]       div_rem;
  logic [DIV_BITS-1:0]       div_quo;
  logic [DIV_BITS-1:0]       div_den_q;
  logic [DIV_BITS:0]         div_trial;

  logic                      scan_load;
  logic                      advance;
  logic [COORD_W-1:0]        bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic [COORD_W-1:0]        scan_x, scan_y;
  logic                      scan_last;

  point_t                    pix_p0;
  logic signed [31:0]        e0_p0, e1_p0, e2_p0;
  logic signed [31:0]        w0_p0, w1_p0, w2_p0;
  logic                      inside_p0;
  logic [4:0]                r_p0, b_p0;
  logic [5:0]                g_p0;
  logic [31:0]               addr_full_p0;

  logic                      issue;
  logic [FB_ADDR_BITS-1:0]   issue_addr;
  logic [FB_DATA_BITS-1:0]   issue_data;
  logic [5:0]                r_full_p0, b_full_p0;

  assign start_ntris  = (num_tris > MAX_N) ? MAX_N : num_tris;
  assign vram_rd_addr = idx;
  assign out_free     = !fb_wr_valid || fb_wr_ready;

  // ---------------------------------------------------------------------
  // Triangle load: area decides skip before the divider is involved
  // ---------------------------------------------------------------------
  assign tri_in   = triangle_t'(vram_rd_data);
  assign area_in  = edge_fn(tri_in.v0, tri_in.v1, tri_in.v2);
  assign skip_in  = (area_in == 32'sd0) || (CULL_BACKFACE && (area_in < 32'sd0));
  assign area_neg = area_q[31];
  assign area_abs = area_neg ? -area_q : area_q;
  assign div_den  = DIV_BITS'($unsigned(area_abs));

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      tri_q  <= tri_in;
      area_q <= area_in;
    end
    if (state == DIV_WAIT && div_valid) inv_q <= div_quo;
  end

  // ---------------------------------------------------------------------
  // Restoring divider: 2^(DIV_BITS-1) / div_den, one quotient bit per cycle
  // ---------------------------------------------------------------------
  assign div_trial = {div_rem, div_quo[DIV_BITS-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_busy  <= 1'b0;
      div_valid <= 1'b0;
      div_cnt   <= '0;
    end else begin
      div_valid <= 1'b0;
      if (div_start) begin
        div_busy <= 1'b1;
        div_cnt  <= '0;
      end else if (div_busy) begin
        div_cnt <= div_cnt + 1'b1;
        if (div_cnt == CNT_LAST) begin
          div_busy  <= 1'b0;
          div_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (div_start) begin
      div_rem   <= '0;
      div_quo   <= {1'b1, {(DIV_BITS-1){1'b0}}};
      div_den_q <= div_den;
    end else if (div_busy) begin
      if (div_trial >= {1'b0, div_den_q}) begin
        div_rem <= DIV_BITS'(div_trial - {1'b0, div_den_q});
        div_quo <= {div_quo[DIV_BITS-2:0], 1'b1};
      end else begin
        div_rem <= div_trial[DIV_BITS-1:0];
        div_quo <= {div_quo[DIV_BITS-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bounding box and scanner
  // ---------------------------------------------------------------------
  assign bb_min_x = clamp(min3(tri_q.v0.x, tri_q.v1.x, tri_q.v2.x), X_LIM);
  assign bb_max_x = clamp(max3(tri_q.v0.x, tri_q.v1.x, tri_q.v2.x), X_LIM);
  assign bb_min_y = clamp(min3(tri_q.v0.y, tri_q.v1.y, tri_q.v2.y), Y_LIM);
  assign bb_max_y = clamp(max3(tri_q.v0.y, tri_q.v1.y, tri_q.v2.y), Y_LIM);

  tri_raster_engine_bbox_scanner u_scanner (
    .clk     (clk),
    .rst     (rst),
    .load    (scan_load),
    .advance (advance),
    .min_x   (bb_min_x),
    .max_x   (bb_max_x),
    .min_y   (bb_min_y),
    .max_y   (bb_max_y),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  // ---------------------------------------------------------------------
  // Stage p0: candidate pixel weights, inside test and shading
  // ---------------------------------------------------------------------
  // Weights are sign-normalised so a back-facing triangle (when not culled)
  // uses the same all-non-negative inside test and |area| as its divisor.
  assign pix_p0    = '{x: scan_x, y: scan_y};
  assign e0_p0     = edge_fn(tri_q.v1, tri_q.v2, pix_p0);
  assign e1_p0     = edge_fn(tri_q.v2, tri_q.v0, pix_p0);
  assign e2_p0     = edge_fn(tri_q.v0, tri_q.v1, pix_p0);
  assign w0_p0     = area_neg ? -e0_p0 : e0_p0;
  assign w1_p0     = area_neg ? -e1_p0 : e1_p0;
  assign w2_p0     = area_neg ? -e2_p0 : e2_p0;
  assign inside_p0 = (w0_p0 >= 0) && (w1_p0 >= 0) && (w2_p0 >= 0);

  assign r_full_p0 = shade_ch(w0_p0, w1_p0, w2_p0, {1'b0, tri_q.c0[15:11]},
                              {1'b0, tri_q.c1[15:11]}, {1'b0, tri_q.c2[15:11]},
                              inv_q, 6'd31);
  assign g_p0      = shade_ch(w0_p0, w1_p0, w2_p0, tri_q.c0[10:5], tri_q.c1[10:5],
                              tri_q.c2[10:5], inv_q, 6'd63);
  assign b_full_p0 = shade_ch(w0_p0, w1_p0, w2_p0, {1'b0, tri_q.c0[4:0]},
                              {1'b0, tri_q.c1[4:0]}, {1'b0, tri_q.c2[4:0]},
                              inv_q, 6'd31);
  assign r_p0         = r_full_p0[4:0];
  assign b_p0         = b_full_p0[4:0];
  assign addr_full_p0 = fb_addr(scan_x, scan_y, DISPLAY_WIDTH);

  // ---------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // The output register is the only pixel stage, so the scanner and the
  // clear counter only move when that register is free this cycle.
  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    advance    = 1'b0;
    scan_load  = 1'b0;
    div_start  = 1'b0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (clear_en)               state_n = CLEAR;
          else if (start_ntris == '0) state_n = DONE;
          else                        state_n = FETCH;
        end
      end
      CLEAR: begin
        if (out_free) begin
          if (!pass_done) begin
            issue      = 1'b1;
            issue_addr = clr_addr;
            issue_data = CLEAR_COLOR;
          end else begin
            state_n = (ntris_q == '0) ? DONE : FETCH;
          end
        end
      end
      FETCH:     state_n = LOAD;
      LOAD:      state_n = skip_in ? NEXT : DIV_START;
      DIV_START: begin
        div_start = 1'b1;
        state_n   = DIV_WAIT;
      end
      DIV_WAIT:  if (div_valid) state_n = SETUP;
      SETUP: begin
        scan_load = 1'b1;
        state_n   = RASTER;
      end
      RASTER: begin
        if (out_free) begin
          if (!pass_done) begin
            advance = 1'b1;
            if (inside_p0) begin
              issue      = 1'b1;
              issue_addr = addr_full_p0[FB_ADDR_BITS-1:0];
              issue_data = FB_DATA_BITS'({r_p0, g_p0, b_p0});
            end
          end else begin
            state_n = NEXT;
          end
        end
      end
      NEXT:    state_n = (({1'b0, idx} + 1'b1) < ntris_q) ? FETCH : DONE;
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame control and output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ntris_q     <= '0;
      idx         <= '0;
      tris_drawn  <= '0;
      pass_done   <= 1'b0;
      clr_addr    <= '0;
      fb_wr_valid <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
    end else begin
      if (state == IDLE && start) begin
        ntris_q    <= start_ntris;
        idx        <= '0;
        tris_drawn <= '0;
      end
      if (state == LOAD && !skip_in) tris_drawn <= tris_drawn + 1'b1;
      if (state == NEXT)             idx        <= idx + 1'b1;

      if (state == CLEAR || state == RASTER) begin
        if (state == CLEAR && issue && clr_addr == CLR_LAST) pass_done <= 1'b1;
        if (advance && scan_last)                            pass_done <= 1'b1;
      end else begin
        pass_done <= 1'b0;
      end

      if (state != CLEAR) clr_addr <= '0;
      else if (issue)     clr_addr <= clr_addr + 1'b1;

      if (issue) begin
        fb_wr_valid <= 1'b1;
        fb_wr_addr  <= issue_addr;
        fb_wr_data  <= issue_data;
      end else if (fb_wr_ready) begin
        fb_wr_valid <= 1'b0;
      end
    end
  end

endmodule
